// File: rtl/adc16dv160_input_axi_write.sv
// AXI-Lite write-only slave holding the ADC16DV160 input control registers.
// Optional macro ADC16DV160_AXI_WSTRB_EN enables per-byte write strobes.
module adc16dv160_input_axi_write #(
    parameter logic [31:0] DSIZE_RST = 32'd0,
    parameter logic [15:0] THR_RST   = 16'd0
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [31:0] AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    output logic [31:0] dsize,
    output logic        cr_test,
    output logic        cr_rt,
    output logic        cr_ls,
    output logic [15:0] ls_start_thr,
    output logic [15:0] ls_stop_thr,
    output logic [31:0] ls_n_start,
    output logic [31:0] ls_n_stop,
    output logic        sr_pc_clr
);

    localparam logic [7:0] ADDR_CR        = 8'h00;
    localparam logic [7:0] ADDR_SR        = 8'h04;
    localparam logic [7:0] ADDR_DSIZE     = 8'h08;
    localparam logic [7:0] ADDR_START_THR = 8'h0C;
    localparam logic [7:0] ADDR_STOP_THR  = 8'h10;
    localparam logic [7:0] ADDR_N_START   = 8'h14;
    localparam logic [7:0] ADDR_N_STOP    = 8'h18;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] cur_word;
    logic [31:0] new_word;
    logic        addr_mapped;
    logic        strb0_ok;
    logic        unused_ok;

`ifdef ADC16DV160_AXI_WSTRB_EN
    function automatic logic [31:0] merge_strb(input logic [31:0] old_word,
                                               input logic [31:0] wr_word,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = wr_word[8*i +: 8];
        end
        return res;
    endfunction
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        AWREADY    = 1'b0;
        WREADY     = 1'b0;
        BVALID     = 1'b0;
        case (state)
            IDLE:    if (AWVALID && WVALID) state_next = ACCEPT;
            ACCEPT: begin
                AWREADY    = 1'b1;
                WREADY     = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                BVALID = 1'b1;
                if (BREADY) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Current contents of the addressed register, so partial-strobe writes keep untouched bytes.
    always_comb begin
        cur_word    = '0;
        addr_mapped = 1'b1;
        case (AWADDR[7:0])
            ADDR_CR:        cur_word = {29'd0, cr_ls, cr_rt, cr_test};
            ADDR_SR:        cur_word = '0;
            ADDR_DSIZE:     cur_word = dsize;
            ADDR_START_THR: cur_word = {16'd0, ls_start_thr};
            ADDR_STOP_THR:  cur_word = {16'd0, ls_stop_thr};
            ADDR_N_START:   cur_word = ls_n_start;
            ADDR_N_STOP:    cur_word = ls_n_stop;
            default:        addr_mapped = 1'b0;
        endcase
    end

`ifdef ADC16DV160_AXI_WSTRB_EN
    assign new_word  = merge_strb(cur_word, WDATA, WSTRB);
    assign strb0_ok  = WSTRB[0];
    assign unused_ok = ^AWADDR[31:8];
`else
    assign new_word  = WDATA;
    assign strb0_ok  = 1'b1;
    assign unused_ok = ^{AWADDR[31:8], WSTRB, cur_word};
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            dsize        <= DSIZE_RST;
            cr_test      <= 1'b0;
            cr_rt        <= 1'b0;
            cr_ls        <= 1'b0;
            ls_start_thr <= THR_RST;
            ls_stop_thr  <= THR_RST;
            ls_n_start   <= '0;
            ls_n_stop    <= '0;
            BRESP        <= RESP_OKAY;
            sr_pc_clr    <= 1'b0;
        end else begin
            sr_pc_clr <= 1'b0;
            if (state == ACCEPT) begin
                BRESP <= addr_mapped ? RESP_OKAY : RESP_SLVERR;
                case (AWADDR[7:0])
                    ADDR_CR: begin
                        cr_test <= new_word[0];
                        cr_rt   <= new_word[1];
                        cr_ls   <= new_word[2];
                    end
                    ADDR_SR:        sr_pc_clr    <= WDATA[0] && strb0_ok;
                    ADDR_DSIZE:     dsize        <= new_word;
                    ADDR_START_THR: ls_start_thr <= new_word[15:0];
                    ADDR_STOP_THR:  ls_stop_thr  <= new_word[15:0];
                    ADDR_N_START:   ls_n_start   <= new_word;
                    ADDR_N_STOP:    ls_n_stop    <= new_word;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/adc16dv160_input_axi_write.md
ADC16DV160_INPUT_AXI_WRITE -- requirements
Module: adc16dv160_input_axi_write

Interface
REQ-001 Parameter DSIZE_RST, 32'd0, reset value of dsize.
REQ-002 Parameter THR_RST, 16'd0, reset value of ls_start_thr and ls_stop_thr.
REQ-003 ACLK  in  1  clock; all logic rising-edge.
REQ-004 ARESETN  in  1  reset, asynchronous, active-low.
REQ-005 AWADDR  in  32  write address; only [7:0] decoded.
REQ-006 AWVALID in 1, AWREADY out 1  AXI-Lite write-address handshake.
REQ-007 WDATA in 32, WSTRB in 4, WVALID in 1, WREADY out 1  AXI-Lite write-data channel.
REQ-008 BRESP out 2, BVALID out 1, BREADY in 1  AXI-Lite write-response channel.
REQ-009 dsize out 32; cr_test, cr_rt, cr_ls out 1 each; ls_start_thr, ls_stop_thr out 16 each; ls_n_start, ls_n_stop out 32 each  registered control values.
REQ-010 sr_pc_clr  out  1  one-cycle pulse clearing the status PC flag.

Function
REQ-011 Address map on AWADDR[7:0]: 0x00 CR, 0x04 SR, 0x08 DSIZE, 0x0C LS_START_THR, 0x10 LS_STOP_THR, 0x14 LS_N_START, 0x18 LS_N_STOP.
REQ-012 CR bits: [0] cr_test, [1] cr_rt, [2] cr_ls; other bits ignored.
REQ-013 Threshold registers take WDATA[15:0]; WDATA[31:16] ignored.
REQ-014 SR write with WDATA[0]=1 pulses sr_pc_clr high for exactly one cycle (the RESP entry cycle); WDATA[0]=0 no effect.
REQ-015 FSM states IDLE, ACCEPT, RESP; reset state IDLE.
REQ-016 IDLE -> ACCEPT only when AWVALID and WVALID both high in same cycle; one valid alone holds IDLE, no READY asserted.
REQ-017 ACCEPT: AWREADY=WREADY=1 for exactly one cycle; AWADDR/WDATA/WSTRB sampled on that cycle's closing edge; unconditional -> RESP.
REQ-018 Target register updates on the ACCEPT closing edge; new value visible at outputs in first RESP cycle (2 cycles after AWVALID&WVALID seen in IDLE).
REQ-019 RESP: BVALID=1; BRESP held stable; -> IDLE on cycle where BREADY=1; BVALID stays high while BREADY=0.
REQ-020 BRESP=2'b00 (OKAY) for mapped addresses; 2'b10 (SLVERR) for unmapped addresses, with no register change and no sr_pc_clr.
REQ-021 Back-to-back: after RESP->IDLE, next transaction accepted no earlier than following IDLE cycle; AWREADY/WREADY never high outside ACCEPT.
REQ-022 BVALID, AWREADY, WREADY never asserted simultaneously.
REQ-023 Read-side values unaffected by anything except completed writes; no outputs change in IDLE or RESP except sr_pc_clr deassertion.

Reset
REQ-024 ARESETN low: FSM to IDLE, AWREADY=WREADY=BVALID=0, BRESP=2'b00, sr_pc_clr=0, immediately (asynchronous).
REQ-025 Reset values: dsize=DSIZE_RST, cr_test=cr_rt=cr_ls=0, ls_start_thr=ls_stop_thr=THR_RST, ls_n_start=ls_n_stop=0.
REQ-026 Reset mid-transaction (ACCEPT or RESP) aborts it; no response issued after release; registers hold reset values.
REQ-027 Deassertion synchronous to ACLK; first transaction may be accepted in first cycle after release.

Configuration
REQ-028 Macro ADC16DV160_AXI_WSTRB_EN defined: only bytes with WSTRB[n]=1 update (byte n = bits [8n+7:8n]); SR pulse requires WSTRB[0]=1; WSTRB=0 gives OKAY, no change.
REQ-029 Macro undefined: WSTRB ignored; every accepted write updates the whole register.

Verification
REQ-030 Write 0x08 data 0x0000_1000, BREADY=1 -> AWREADY/WREADY one cycle, BVALID next cycle with BRESP=00, dsize=0x1000.
REQ-031 Write 0x00 data 0x5 -> cr_test=1, cr_rt=0, cr_ls=1; BRESP=00.
REQ-032 Write 0x3C data 0xFFFF_FFFF -> BRESP=10, all outputs unchanged.
REQ-033 Write 0x04 data 0x1, BREADY low 5 cycles -> sr_pc_clr one cycle only, BVALID held 5 cycles, drops cycle after BREADY=1.
REQ-034 AWVALID only for 10 cycles then WVALID -> no READY until both high; write 0x0C data 0xABCD_1234 -> ls_start_thr=0x1234.
REQ-035 ARESETN low during RESP -> BVALID=0 immediately, all registers at reset values; with ADC16DV160_AXI_WSTRB_EN, write 0x14 data 0xFFFF_FFFF WSTRB=4'b0010 -> ls_n_start=0x0000_FF00.
